// File: rtl/vme_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : vme_seq_pkg                                                      |
// | Shared op/state encodings and the result record for vme_cmd_sequencer.     |
// | VME_SEQ_COMPARE_EN adds a mismatch flag to the result record.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vme_seq_pkg;

  localparam int RD_BIT     = 25;
  localparam int WR_BIT     = 24;
  localparam int MAX_ADDR_W = 24;
  localparam int MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Sized for the widest legal configuration; the top slices what it needs.
  typedef struct packed {
    op_e                   op;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic                  timeout;
`ifdef VME_SEQ_COMPARE_EN
    logic                  mismatch;
`endif
  } res_t;

endpackage
`default_nettype wire

// File: rtl/vme_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : vme_cmd_sequencer_if                                           |
// | Loader, playback control, VME decoder and result-queue signals.            |
// | VME_SEQ_COMPARE_EN adds res_mismatch and mismatch_cnt.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vme_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic              load_valid;
  logic              load_ready;
  logic [1:0]        load_op;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_clr;
  logic              go;
  logic              busy;
  logic              done;
  logic              vme_cmd_rd;
  logic              start;
  logic [31:0]       vme_cmd_reg;
  logic [31:0]       vme_dat_reg_in;
  logic              vme_dat_wr;
  logic [31:0]       vme_dat_reg_out;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_op;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
`ifdef VME_SEQ_COMPARE_EN
  logic              res_mismatch;
  logic [15:0]       mismatch_cnt;
`endif

  modport master (
    output load_valid, load_op, load_addr, load_data, load_clr, go,
           vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, res_ready,
    input  load_ready, busy, done, start, vme_cmd_reg, vme_dat_reg_in,
           res_valid, res_op, res_addr, res_data, res_timeout
`ifdef VME_SEQ_COMPARE_EN
    , input res_mismatch, mismatch_cnt
`endif
  );

  modport slave (
    input  load_valid, load_op, load_addr, load_data, load_clr, go,
           vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, res_ready,
    output load_ready, busy, done, start, vme_cmd_reg, vme_dat_reg_in,
           res_valid, res_op, res_addr, res_data, res_timeout
`ifdef VME_SEQ_COMPARE_EN
    , output res_mismatch, mismatch_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/vme_seq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vme_seq_fifo                                                     |
// | Generic synchronous FIFO; push while full is accepted when popping too.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vme_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule
`default_nettype wire

// File: rtl/vme_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vme_cmd_sequencer                                                |
// | Stores a R/W/NOP/END program and replays it into the VME command/data      |
// | registers on go, queueing one result per R/W. VME_SEQ_COMPARE_EN enables   |
// | expected-data comparison for reads and the mismatch counter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vme_cmd_sequencer
  import vme_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RES_DEPTH = 16,
  parameter logic [31:0] CMD_MASK  = 32'h00A80000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input logic               clk,
  input logic               rst_n,
  vme_cmd_sequencer_if.slave bus
);
  localparam int unsigned   IW       = $clog2(DEPTH);
  localparam int unsigned   PW       = IW + 1;
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [PW-1:0]     count_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic              start_q, start_d;
  logic              zdone_q, zdone_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       dat_q, dat_d;

  logic [1:0]        prog_op_q   [DEPTH];
  logic [ADDR_W-1:0] prog_addr_q [DEPTH];
  logic [DATA_W-1:0] prog_data_q [DEPTH];

  op_e               w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_idle, w_go, w_load_ready, w_load_acc;
  logic              w_push, w_tmo, w_res_full, w_res_empty;
  res_t              w_res, w_res_rd;
  logic              w_unused_bits;

  assign w_op         = op_e'(prog_op_q[pc_q[IW-1:0]]);
  assign w_addr       = prog_addr_q[pc_q[IW-1:0]];
  assign w_data       = prog_data_q[pc_q[IW-1:0]];
  assign w_rd_data    = bus.vme_dat_reg_out[DATA_W-1:0];
  assign w_idle       = (state_q == S_IDLE);
  assign w_go         = w_idle && bus.go;
  assign w_load_ready = w_idle && (count_q != FULL_CNT);
  assign w_load_acc   = bus.load_valid && w_load_ready && !bus.load_clr;
  // A response arriving on the expiry cycle is treated as a normal response.
  assign w_tmo        = !bus.vme_dat_wr && (timer_q == TMO_CNT);

  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      prog_op_q[count_q[IW-1:0]]   <= bus.load_op;
      prog_addr_q[count_q[IW-1:0]] <= bus.load_addr;
      prog_data_q[count_q[IW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (w_idle && bus.load_clr) begin
      count_q <= '0;
    end else if (w_load_acc) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      zdone_q <= 1'b0;
      cmd_q   <= CMD_MASK;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      timer_q <= timer_d;
      start_q <= start_d;
      zdone_q <= zdone_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    timer_d = timer_q;
    start_d = 1'b0;
    zdone_d = 1'b0;
    cmd_d   = CMD_MASK;
    dat_d   = '0;
    w_push  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          if (count_q == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            pc_d    = '0;
          end
        end
      end
      S_FETCH: begin
        if ((pc_q == count_q) || (w_op == OP_END)) begin
          state_d = S_DONE;
        end else if (w_op == OP_NOP) begin
          pc_d = pc_q + 1'b1;
        end else if (!w_res_full) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.vme_cmd_rd) begin
          start_d = 1'b1;
          cmd_d   = CMD_MASK | (32'(w_op == OP_READ) << RD_BIT)
                             | (32'(w_op == OP_WRITE) << WR_BIT) | 32'(w_addr);
          dat_d   = (w_op == OP_WRITE) ? 32'(w_data) : 32'd0;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.vme_dat_wr || w_tmo) begin
          w_push  = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_res      = '0;
    w_res.op   = w_op;
    w_res.addr = MAX_ADDR_W'(w_addr);
    if (w_tmo) begin
      w_res.timeout = 1'b1;
    end else begin
      w_res.data = MAX_DATA_W'((w_op == OP_READ) ? w_rd_data : w_data);
    end
`ifdef VME_SEQ_COMPARE_EN
    w_res.mismatch = w_tmo || ((w_op == OP_READ) && (w_rd_data != w_data));
`endif
  end

  vme_seq_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (w_res),
    .pop_i   (bus.res_ready),
    .rdata_o (w_res_rd),
    .full_o  (w_res_full),
    .empty_o (w_res_empty)
  );

`ifdef VME_SEQ_COMPARE_EN
  logic [15:0] mcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q <= '0;
    end else if (w_go) begin
      mcnt_q <= '0;
    end else if (w_push && w_res.mismatch && (mcnt_q != 16'hFFFF)) begin
      mcnt_q <= mcnt_q + 1'b1;
    end
  end
  assign bus.res_mismatch = !w_res_empty && w_res_rd.mismatch;
  assign bus.mismatch_cnt = mcnt_q;
`endif

  assign bus.load_ready     = w_load_ready;
  assign bus.busy           = !w_idle;
  assign bus.done           = (state_q == S_DONE) || zdone_q;
  assign bus.start          = start_q;
  assign bus.vme_cmd_reg    = cmd_q;
  assign bus.vme_dat_reg_in = dat_q;
  assign bus.res_valid      = !w_res_empty;
  assign bus.res_op         = w_res_rd.op;
  assign bus.res_addr       = w_res_rd.addr[ADDR_W-1:0];
  assign bus.res_data       = w_res_rd.data[DATA_W-1:0];
  // Stale FIFO storage must not show a timeout flag after reset.
  assign bus.res_timeout    = !w_res_empty && w_res_rd.timeout;

  assign w_unused_bits = ^{w_res_rd, bus.vme_dat_reg_out};
endmodule
`default_nettype wire

// File: tb/tb_vme_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vme_cmd_sequencer                                             |
// | Table-driven program playback plus stall, timeout, backpressure and reset  |
// | sequences. VME_SEQ_COMPARE_EN enables the read-compare sequence.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vme_cmd_sequencer;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] exp_cmd;
    logic [31:0] exp_dat;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tmo;
  } r_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsp_en = 1'b1;
  logic        rsp_arm = 1'b0;
  logic        rsp_wr = 1'b0;
  logic [31:0] rsp_val = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  logic [63:0] cmd_q [$];
  r_t          res_q [$];
  vec_t        tbl [7];

  always #5 clk = ~clk;

  vme_cmd_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  vme_cmd_sequencer #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(64), .RES_DEPTH(16),
    .CMD_MASK(32'h00A80000), .TIMEOUT(1023)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.vme_dat_wr      = rsp_wr;
  assign bus.vme_dat_reg_out = rsp_val;

  // Decoder model: answers each start two cycles later with addr + 0x1000.
  always @(negedge clk) begin
    rsp_wr = 1'b0;
    if (!rst_n) begin
      rsp_arm = 1'b0;
    end else if (rsp_arm) begin
      rsp_wr  = 1'b1;
      rsp_arm = 1'b0;
    end else if (rsp_en && bus.start) begin
      rsp_arm = 1'b1;
      rsp_val = {16'h0000, bus.vme_cmd_reg[15:0] + 16'h1000};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start) begin
        start_cnt++;
        cmd_q.push_back({bus.vme_cmd_reg, bus.vme_dat_reg_in});
      end
      if (bus.done) done_cnt++;
      if (bus.res_valid && bus.res_ready)
        res_q.push_back('{bus.res_op, bus.res_addr, bus.res_data, bus.res_timeout});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    bus.load_valid = 1'b1;
    bus.load_op    = op;
    bus.load_addr  = a;
    bus.load_data  = d;
    tick(1);
    bus.load_valid = 1'b0;
  endtask

  task automatic clear_prog();
    bus.load_clr = 1'b1;
    tick(1);
    bus.load_clr = 1'b0;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    tick(1);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < bound) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_start(input string nm, input int bound);
    int k = 0;
    while (!bus.start && k < bound) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(bus.start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int k;
    tbl[0] = '{2'b01, 16'h1234, 16'hBEEF, 32'h01A81234, 32'h0000BEEF, 16'hBEEF};
    tbl[1] = '{2'b10, 16'h5678, 16'h0000, 32'h02A85678, 32'h00000000, 16'h6678};
    tbl[2] = '{2'b00, 16'h0000, 16'h0000, 32'h0,        32'h0,        16'h0000};
    tbl[3] = '{2'b01, 16'h00FF, 16'h0001, 32'h01A800FF, 32'h00000001, 16'h0001};
    tbl[4] = '{2'b10, 16'hFFFF, 16'h0000, 32'h02A8FFFF, 32'h00000000, 16'h0FFF};
    tbl[5] = '{2'b11, 16'h0000, 16'h0000, 32'h0,        32'h0,        16'h0000};
    tbl[6] = '{2'b01, 16'h4444, 16'h5555, 32'h01A84444, 32'h00005555, 16'h5555};

    bus.load_valid = 1'b0;
    bus.load_op    = 2'b00;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_clr   = 1'b0;
    bus.go         = 1'b0;
    bus.vme_cmd_rd = 1'b1;
    bus.res_ready  = 1'b1;

    tick(3);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_done",    32'(bus.done),        32'd0);
    chk("rst_start",   32'(bus.start),       32'd0);
    chk("rst_resv",    32'(bus.res_valid),   32'd0);
    chk("rst_cmd",     bus.vme_cmd_reg,      32'h00A80000);
    chk("rst_dat",     bus.vme_dat_reg_in,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("idle_ready",  32'(bus.load_ready),  32'd1);

    // Table-driven playback, including a NOP and an entry after END.
    for (int i = 0; i < 7; i++) load(tbl[i].op, tbl[i].addr, tbl[i].data);
    s0 = start_cnt;
    pulse_go();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_done("t1_done", 300);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].op == 2'b11) break;
      if (tbl[i].op != 2'b00) begin
        if (cmd_q.size() == 0 || res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL t1_entry_%0d: no command/result seen, one required", i);
        end else begin
          logic [63:0] c;
          r_t          r;
          c = cmd_q.pop_front();
          r = res_q.pop_front();
          chk($sformatf("t1_cmd_%0d", i),  c[63:32],        tbl[i].exp_cmd);
          chk($sformatf("t1_dat_%0d", i),  c[31:0],         tbl[i].exp_dat);
          chk($sformatf("t1_rop_%0d", i),  32'(r.op),       32'(tbl[i].op));
          chk($sformatf("t1_radr_%0d", i), 32'(r.addr),     32'(tbl[i].addr));
          chk($sformatf("t1_rdat_%0d", i), 32'(r.data),     32'(tbl[i].exp_res));
          chk($sformatf("t1_rtmo_%0d", i), 32'(r.tmo),      32'd0);
        end
      end
    end
    chk("t1_extra_cmds", 32'(cmd_q.size()), 32'd0);
    chk("t1_starts",     32'(start_cnt - s0), 32'd4);
    chk("t1_idle_busy",  32'(bus.busy), 32'd0);
    s0 = start_cnt;
    pulse_go();
    wait_done("t1_rerun_done", 300);
    chk("t1_rerun_starts", 32'(start_cnt - s0), 32'd4);
    cmd_q.delete();
    res_q.delete();

    // Decoder not ready: command held back.
    clear_prog();
    load(2'b01, 16'h1111, 16'h2222);
    load(2'b11, 16'h0000, 16'h0000);
    bus.vme_cmd_rd = 1'b0;
    s0 = start_cnt;
    pulse_go();
    tick(50);
    chk("t2_no_start", 32'(start_cnt - s0), 32'd0);
    chk("t2_cmd_idle", bus.vme_cmd_reg,     32'h00A80000);
    chk("t2_busy",     32'(bus.busy),       32'd1);
    chk("t2_no_load",  32'(bus.load_ready), 32'd0);
    bus.vme_cmd_rd = 1'b1;
    wait_done("t2_done", 50);
    chk("t2_one_start", 32'(start_cnt - s0), 32'd1);
    chk("t2_cmd", (cmd_q.size() > 0) ? cmd_q[0][63:32] : 32'hDEAD_0000, 32'h01A81111);
    cmd_q.delete();
    res_q.delete();

    // No response: timeout result.
    clear_prog();
    load(2'b10, 16'h3333, 16'h0000);
    load(2'b11, 16'h0000, 16'h0000);
    rsp_en = 1'b0;
    bus.res_ready = 1'b0;
    pulse_go();
    wait_start("t3_start", 20);
    k = 0;
    while (!bus.res_valid && k < 2000) begin
      tick(1);
      k++;
    end
    chk("t3_latency", 32'(k),               32'd1024);
    chk("t3_tmo",     32'(bus.res_timeout), 32'd1);
    chk("t3_data",    32'(bus.res_data),    32'd0);
    chk("t3_op",      32'(bus.res_op),      32'd2);
    chk("t3_addr",    32'(bus.res_addr),    32'h3333);
    bus.res_ready = 1'b1;
    wait_done("t3_done", 20);
    chk("t3_popped", 32'(bus.res_valid), 32'd0);
    rsp_en = 1'b1;
    cmd_q.delete();
    res_q.delete();

    // Result FIFO backpressure: 20 writes, only 16 issue until popped.
    clear_prog();
    for (int i = 0; i < 20; i++) load(2'b01, 16'(i), 16'(i * 3));
    load(2'b11, 16'h0000, 16'h0000);
    bus.res_ready = 1'b0;
    s0 = start_cnt;
    pulse_go();
    tick(300);
    chk("t4_stall_starts", 32'(start_cnt - s0), 32'd16);
    chk("t4_busy",         32'(bus.busy),       32'd1);
    chk("t4_resv",         32'(bus.res_valid),  32'd1);
    bus.res_ready = 1'b1;
    wait_done("t4_done", 500);
    tick(2);
    chk("t4_total_starts", 32'(start_cnt - s0), 32'd20);
    chk("t4_results",      32'(res_q.size()),   32'd20);
    if (res_q.size() == 20) begin
      chk("t4_first_addr", 32'(res_q[0].addr),  32'h0000);
      chk("t4_last_addr",  32'(res_q[19].addr), 32'h0013);
      chk("t4_last_data",  32'(res_q[19].data), 32'h0039);
    end
    cmd_q.delete();
    res_q.delete();

    // Reset while waiting for a response.
    clear_prog();
    load(2'b10, 16'h4444, 16'h0000);
    load(2'b11, 16'h0000, 16'h0000);
    rsp_en = 1'b0;
    pulse_go();
    wait_start("t5_start", 20);
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  32'(bus.busy),        32'd0);
    chk("t5_start", 32'(bus.start),       32'd0);
    chk("t5_done",  32'(bus.done),        32'd0);
    chk("t5_resv",  32'(bus.res_valid),   32'd0);
    chk("t5_tmo",   32'(bus.res_timeout), 32'd0);
    chk("t5_cmd",   bus.vme_cmd_reg,      32'h00A80000);
    chk("t5_dat",   bus.vme_dat_reg_in,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_en = 1'b1;
    tick(1);
    s0 = start_cnt;
    d0 = done_cnt;
    pulse_go();
    tick(2);
    chk("t5_empty_done",  32'(done_cnt - d0),  32'd1);
    chk("t5_empty_start", 32'(start_cnt - s0), 32'd0);
    chk("t5_empty_busy",  32'(bus.busy),       32'd0);

    // Clear wins over a same-cycle load.
    load(2'b01, 16'h7777, 16'h0001);
    bus.load_clr   = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_op    = 2'b01;
    tick(1);
    bus.load_clr   = 1'b0;
    bus.load_valid = 1'b0;
    s0 = start_cnt;
    d0 = done_cnt;
    pulse_go();
    tick(2);
    chk("t5_clr_done",  32'(done_cnt - d0),  32'd1);
    chk("t5_clr_start", 32'(start_cnt - s0), 32'd0);
    cmd_q.delete();
    res_q.delete();

`ifdef VME_SEQ_COMPARE_EN
    // Expected-data compare: first read mismatches, second matches.
    clear_prog();
    load(2'b10, 16'h9AAB, 16'hAAAA);
    load(2'b10, 16'h0123, 16'h1123);
    load(2'b11, 16'h0000, 16'h0000);
    bus.res_ready = 1'b0;
    pulse_go();
    wait_done("t6_done", 100);
    chk("t6_mis0",  32'(bus.res_mismatch), 32'd1);
    chk("t6_data0", 32'(bus.res_data),     32'hAAAB);
    bus.res_ready = 1'b1;
    tick(1);
    bus.res_ready = 1'b0;
    chk("t6_mis1",  32'(bus.res_mismatch), 32'd0);
    chk("t6_cnt",   32'(bus.mismatch_cnt), 32'd1);
    bus.res_ready = 1'b1;
    tick(1);
    pulse_go();
    chk("t6_cnt_clr", 32'(bus.mismatch_cnt), 32'd0);
    wait_done("t6_rerun_done", 100);
    chk("t6_cnt_rerun", 32'(bus.mismatch_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
